grab_detector: RTL and testbench

GRAB_DETECTOR -- requirements
Module: grab_detector

---
 rtl/climber_video_pkg.sv | 23 ++
 rtl/overlap_accum.sv | 40 ++++
 rtl/grab_detector.sv | 120 ++++++++++++
 tb/tb_grab_detector.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/climber_video_pkg.sv
// Shared video-side definitions for the climber overlay blocks: raster defaults,
// field widths and the grab detector FSM encoding.
package climber_video_pkg;

    localparam int H_ACTIVE_DEF    = 1024;
    localparam int V_ACTIVE_DEF    = 768;
    localparam int MIN_OVERLAP_DEF = 16;

    localparam int HW = 11;
    localparam int VW = 10;
    localparam int CW = 16;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        SCAN       = 2'd1,
        BLANK      = 2'd2
    } grab_state_t;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] value);
        return (value == {CW{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/overlap_accum.sv
// Saturating overlap-pixel accumulator; remembers the raster position of the
// first hit since the last clear.
module overlap_accum
    import climber_video_pkg::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic          hit,
    input  logic          clear,
    input  logic [HW-1:0] hcount,
    input  logic [VW-1:0] vcount,
    output logic [CW-1:0] acc,
    output logic          first_seen,
    output logic [HW-1:0] first_x,
    output logic [VW-1:0] first_y
);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            first_seen <= 1'b0;
            first_x    <= '0;
            first_y    <= '0;
        end else if (clear) begin
            acc        <= '0;
            first_seen <= 1'b0;
            first_x    <= '0;
            first_y    <= '0;
        end else if (hit) begin
            acc <= sat_inc(acc);
            // Only the earliest hit in raster order is kept for the frame.
            if (!first_seen) begin
                first_seen <= 1'b1;
                first_x    <= hcount;
                first_y    <= vcount;
            end
        end
    end

endmodule

// File: rtl/grab_detector.sv
// Counts hand/hold overlap pixels per video frame and publishes a registered
// per-frame result with a simple valid/ack handshake and sticky overrun flag.
//
// state      | meaning
// WAIT_FRAME | after reset: ignore pixels until the raster origin (0,0)
// SCAN       | accumulating overlap over the frame
// BLANK      | result latched, waiting for the next frame origin
module grab_detector
    import climber_video_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_DEF,
    parameter int V_ACTIVE    = V_ACTIVE_DEF,
    parameter int MIN_OVERLAP = MIN_OVERLAP_DEF
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [HW-1:0] hcount,
    input  logic [VW-1:0] vcount,
    input  logic          hold_exists,
    input  logic          hand_exists,
    input  logic          result_ack,
    output logic          result_valid,
    output logic          grab,
    output logic [CW-1:0] overlap_count,
    output logic [HW-1:0] hit_x,
    output logic [VW-1:0] hit_y,
    output logic          overrun
);

    localparam logic [HW-1:0] H_LIM   = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_LIM   = VW'(V_ACTIVE);
    localparam logic [CW-1:0] MIN_LIM = CW'(MIN_OVERLAP);

    grab_state_t   state;
    grab_state_t   next_state;
    logic          scan_pixel;
    logic          frame_end;
    logic          at_origin;
    logic          at_end;
    logic          active;
    logic          hit;
    logic [CW-1:0] acc;
    logic          first_seen;
    logic [HW-1:0] first_x;
    logic [VW-1:0] first_y;

    assign at_origin = (hcount == '0) && (vcount == '0);
    assign at_end    = (hcount == '0) && (vcount == V_LIM);
    assign active    = (hcount < H_LIM) && (vcount < V_LIM);
    assign hit       = scan_pixel && active && hold_exists && hand_exists;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_FRAME;
        end else begin
            state <= next_state;
        end
    end

    // The origin pixel that starts a frame is itself part of that frame.
    always_comb begin
        next_state = state;
        scan_pixel = 1'b0;
        frame_end  = 1'b0;
        case (state)
            WAIT_FRAME, BLANK: begin
                if (at_origin) begin
                    next_state = SCAN;
                    scan_pixel = 1'b1;
                end
            end
            SCAN: begin
                if (at_end) begin
                    next_state = BLANK;
                    frame_end  = 1'b1;
                end else begin
                    scan_pixel = 1'b1;
                end
            end
            default: next_state = WAIT_FRAME;
        endcase
    end

    overlap_accum u_accum (
        .clock      (clock),
        .reset_n    (reset_n),
        .hit        (hit),
        .clear      (frame_end),
        .hcount     (hcount),
        .vcount     (vcount),
        .acc        (acc),
        .first_seen (first_seen),
        .first_x    (first_x),
        .first_y    (first_y)
    );

    // A latch coinciding with an ack keeps the new result valid and is not an overrun.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result_valid  <= 1'b0;
            grab          <= 1'b0;
            overlap_count <= '0;
            hit_x         <= '0;
            hit_y         <= '0;
            overrun       <= 1'b0;
        end else if (frame_end) begin
            result_valid  <= 1'b1;
            grab          <= (acc >= MIN_LIM);
            overlap_count <= acc;
            hit_x         <= first_seen ? first_x : '0;
            hit_y         <= first_seen ? first_y : '0;
            if (result_valid && !result_ack) begin
                overrun <= 1'b1;
            end
        end else if (result_valid && result_ack) begin
            result_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_grab_detector.sv
// Randomized scoreboard bench for grab_detector: a frame-level reference model
// predicts the published result; a monitor compares at the scheduled cycles.
module tb_grab_detector;
    import climber_video_pkg::*;

    localparam int H   = 1024;
    localparam int V   = 768;
    localparam int MIN = 16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hold_exists = 1'b0;
    logic        hand_exists = 1'b0;
    logic        result_ack = 1'b0;
    logic        result_valid;
    logic        grab;
    logic [15:0] overlap_count;
    logic [10:0] hit_x;
    logic [9:0]  hit_y;
    logic        overrun;

    grab_detector #(.H_ACTIVE(H), .V_ACTIVE(V), .MIN_OVERLAP(MIN)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .hcount        (hcount),
        .vcount        (vcount),
        .hold_exists   (hold_exists),
        .hand_exists   (hand_exists),
        .result_ack    (result_ack),
        .result_valid  (result_valid),
        .grab          (grab),
        .overlap_count (overlap_count),
        .hit_x         (hit_x),
        .hit_y         (hit_y),
        .overrun       (overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        int    cyc;
        bit    valid;
        bit    grab;
        int    count;
        int    hx;
        int    hy;
        bit    ovr;
        string tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    // Reference model: frame membership, raw overlap tally, first hit, published result.
    bit   m_in_frame = 0;
    int   m_count = 0;
    bit   m_seen = 0;
    int   m_hx = 0;
    int   m_hy = 0;
    exp_t m_out = '{0, 0, 0, 0, 0, 0, 0, "model"};

    task automatic push_model(input string tag);
        exp_t e;
        e = m_out;
        e.cyc = cyc;
        e.tag = tag;
        q.push_back(e);
    endtask

    task automatic push_const(input string tag, input bit v, input bit g, input int c,
                              input int x, input int y, input bit o);
        exp_t e;
        e = '{cyc, v, g, c, x, y, o, tag};
        q.push_back(e);
    endtask

    task automatic step(input int h, input int v, input bit ho, input bit ha, input bit ack);
        bit   act;
        bit   fend;
        exp_t prev;
        hcount = 11'(h);
        vcount = 10'(v);
        hold_exists = ho;
        hand_exists = ha;
        result_ack = ack;
        @(posedge clock);
        cyc++;
        prev = m_out;
        fend = 0;
        if (reset_n) begin
            act  = (h < H) && (v < V);
            fend = m_in_frame && (v == V) && (h == 0);
            if (fend) begin
                m_out.ovr   = m_out.ovr | (m_out.valid && !ack);
                m_out.valid = 1;
                m_out.count = (m_count > 65535) ? 65535 : m_count;
                m_out.grab  = (m_count >= MIN);
                m_out.hx    = m_seen ? m_hx : 0;
                m_out.hy    = m_seen ? m_hy : 0;
                m_count = 0;
                m_seen = 0;
                m_in_frame = 0;
            end else begin
                if (ack && m_out.valid) m_out.valid = 0;
                if (!m_in_frame && h == 0 && v == 0) m_in_frame = 1;
                if (m_in_frame && act && ho && ha) begin
                    m_count++;
                    if (!m_seen) begin
                        m_seen = 1;
                        m_hx = h;
                        m_hy = v;
                    end
                end
            end
        end
        if (fend) push_model("frame_result");
        else if (prev.valid != m_out.valid || prev.ovr != m_out.ovr) push_model("output_change");
        else if ($urandom_range(0, 63) == 0) push_model("stable");
        #1;
    endtask

    task automatic idle(input int n, input bit ack);
        for (int i = 0; i < n; i++) step(1200, 500, 0, 0, ack);
    endtask

    task automatic rect(input int x, input int y, input int w, input int hgt);
        for (int r = 0; r < hgt; r++)
            for (int c = 0; c < w; c++) step(x + c, y + r, 1, 1, 0);
    endtask

    // both=0 never drives an overlapping pixel; out-of-range coordinates included.
    task automatic noise(input int n, input bit both, input bit ackrand);
        int h;
        int v;
        bit ho;
        bit ha;
        for (int i = 0; i < n; i++) begin
            h = $urandom_range(0, 1279);
            v = $urandom_range(0, 799);
            if (h == 0) h = 1;
            ho = 1'($urandom_range(0, 1));
            ha = both ? 1'($urandom_range(0, 1)) : !ho;
            step(h, v, ho, ha, ackrand && ($urandom_range(0, 7) == 0));
        end
    endtask

    task automatic start_frame();
        step(0, 0, 0, 0, 0);
    endtask

    task automatic end_frame(input bit ack);
        step(0, V, 0, 0, ack);
    endtask

    task automatic do_reset();
        reset_n = 0;
        m_in_frame = 0;
        m_count = 0;
        m_seen = 0;
        m_out = '{0, 0, 0, 0, 0, 0, 0, "model"};
        push_model("reset_async");
        idle(2, 0);
        reset_n = 1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                checks++;
                if (e.cyc != cyc || result_valid !== e.valid || grab !== e.grab ||
                    overlap_count !== 16'(e.count) || hit_x !== 11'(e.hx) ||
                    hit_y !== 10'(e.hy) || overrun !== e.ovr) begin
                    failures++;
                    $display("FAIL %s cyc=%0d/%0d got v=%0b g=%0b cnt=%0d x=%0d y=%0d ovr=%0b want v=%0b g=%0b cnt=%0d x=%0d y=%0d ovr=%0b",
                             e.tag, cyc, e.cyc, result_valid, grab, overlap_count, hit_x, hit_y,
                             overrun, e.valid, e.grab, e.count, e.hx, e.hy, e.ovr);
                end
            end
        end
    end

    initial begin : watchdog
        #5000000;
        $display("FAIL watchdog got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int x;
        int y;
        push_const("reset_state", 0, 0, 0, 0, 0, 0);
        #12;
        idle(2, 0);
        reset_n = 1;
        idle(2, 0);

        // Overlap before the first origin is ignored.
        rect(50, 50, 4, 4);
        noise(10, 1, 0);

        start_frame();
        noise(20, 0, 0);
        rect(100, 200, 10, 10);
        noise(20, 0, 0);
        end_frame(0);
        push_const("frame_10x10", 1, 1, 100, 100, 200, 0);
        idle(3, 0);
        idle(1, 1);
        push_const("ack_drops_valid", 0, 1, 100, 100, 200, 0);
        idle(2, 1);

        x = $urandom_range(200, 900);
        y = $urandom_range(10, 700);
        start_frame();
        noise(15, 0, 0);
        rect(x, y, 3, 5);
        end_frame(0);
        push_const("frame_3x5", 1, 0, 15, x, y, 0);
        idle(2, 0);

        start_frame();
        noise(30, 0, 0);
        end_frame(0);
        push_const("no_overlap_overrun", 1, 0, 0, 0, 0, 1);
        idle(2, 0);
        idle(1, 1);
        push_const("ack_keeps_overrun", 0, 0, 0, 0, 0, 1);
        idle(2, 0);

        start_frame();
        rect(900, 100, 2, 2);
        for (int i = 0; i < 20; i++) step(1100, $urandom_range(0, 767), 1, 1, 0);
        for (int i = 0; i < 20; i++) step($urandom_range(1, 1023), 770, 1, 1, 0);
        end_frame(0);
        push_const("out_of_range", 1, 0, 4, 900, 100, 1);
        idle(1, 1);

        start_frame();
        for (int r = 1; r <= 65; r++)
            for (int c = 0; c < H; c++) step(c, r, 1, 1, 0);
        end_frame(0);
        push_const("saturation", 1, 1, 65535, 0, 1, 1);
        idle(2, 0);

        start_frame();
        rect(100, 100, 3, 3);
        step(500, 300, 0, 0, 0);
        do_reset();
        rect(400, 400, 4, 4);
        end_frame(0);
        idle(2, 0);
        push_const("reset_discards_partial", 0, 0, 0, 0, 0, 0);
        start_frame();
        rect(300, 350, 6, 6);
        noise(10, 0, 0);
        end_frame(0);
        push_const("first_after_reset", 1, 1, 36, 300, 350, 0);
        idle(2, 0);

        start_frame();
        rect(600, 500, 4, 4);
        noise(10, 0, 0);
        end_frame(1);
        push_const("ack_on_latch", 1, 1, 16, 600, 500, 0);
        idle(2, 0);

        for (int f = 0; f < 8; f++) begin
            start_frame();
            noise($urandom_range(5, 40), 1, 1);
            rect($urandom_range(1, 1015), $urandom_range(1, 759),
                 $urandom_range(0, 8), $urandom_range(0, 8));
            noise($urandom_range(5, 40), 1, 1);
            end_frame(1'($urandom_range(0, 1)));
            idle($urandom_range(1, 6), 1'($urandom_range(0, 1)));
        end

        idle(3, 0);
        push_model("final_state");
        idle(1, 0);
        @(negedge clock);
        #1;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
